// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing the async FIFO write port between NUM_REQ producers.
// A grant lasts up to BURST_LEN words; one idle arbitration cycle separates consecutive bursts.
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int BURST_LEN  = 8,
    localparam int OWNER_W    = $clog2(NUM_REQ),
    localparam int CNT_W      = $clog2(BURST_LEN + 1)
) (
    input  logic                          w_clk,
    input  logic                          wrst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          fifo_full,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          wr_req,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic [OWNER_W-1:0]            owner,
    output logic                          busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic [OWNER_W-1:0] last_q, last_d;
    logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

    logic               found;
    logic [OWNER_W-1:0] pick;
    logic [OWNER_W-1:0] cand;

    // Search starts just after the previous winner so every requester gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = OWNER_W'((int'(last_q) + k) % NUM_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign busy     = (state_q == BURST);
    assign wr_req   = busy && req[owner_q] && !fifo_full;
    assign ack      = wr_req ? (NUM_REQ'(1) << owner_q) : '0;
    assign data_out = wr_req ? req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign owner    = owner_q;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        beat_cnt_d = beat_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d    = BURST;
                    owner_d    = pick;
                    last_d     = pick;
                    beat_cnt_d = '0;
                end
            end
            BURST: begin
                if (wr_req) begin
                    if (beat_cnt_q == CNT_W'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end else if (!req[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset leaves last at NUM_REQ-1 so requester 0 wins the first arbitration.
    always_ff @(posedge w_clk or posedge wrst) begin
        if (wrst) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            last_q     <= OWNER_W'(NUM_REQ - 1);
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: hand tables, directed corner sequences and a random
// stream checked against a grant/words-left reference model and a FIFO scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic          w_clk = 1'b0;
    logic          wrst  = 1'b1;
    logic [NR-1:0] req   = '0;
    logic          full  = 1'b0;
    logic [DW-1:0] word     [NR];
    logic [DW-1:0] nxt_word [NR];
    logic [NR*DW-1:0] req_data;

    logic [NR-1:0] ack_w  [2];
    logic          wr_w   [2];
    logic [DW-1:0] dat_w  [2];
    logic [1:0]    own_w  [2];
    logic          busy_w [2];

    int checks   = 0;
    int failures = 0;

    // Reference model: which requester holds the grant (-1 none) and how many words it may still write.
    int m_grant [2];
    int m_left  [2];
    int m_last  [2];
    int m_owner [2];
    int blen    [2] = '{8, 1};

    typedef struct {
        logic [NR-1:0] req;
        logic          full;
        logic [NR-1:0] ack;
        logic          busy;
        logic [1:0]    owner;
    } vec_t;
    vec_t tbl[$];

    logic [DW-1:0] sb_q[$];
    int seq     [NR];
    int exp_seq [NR];
    logic [NR-1:0] acked;

    assign req_data = {word[3], word[2], word[1], word[0]};

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(8)) dut (
        .w_clk(w_clk), .wrst(wrst), .req(req), .req_data(req_data), .fifo_full(full),
        .ack(ack_w[0]), .wr_req(wr_w[0]), .data_out(dat_w[0]), .owner(own_w[0]), .busy(busy_w[0])
    );

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(1)) dut_b1 (
        .w_clk(w_clk), .wrst(wrst), .req(req), .req_data(req_data), .fifo_full(full),
        .ack(ack_w[1]), .wr_req(wr_w[1]), .data_out(dat_w[1]), .owner(own_w[1]), .busy(busy_w[1])
    );

    always #5 w_clk = ~w_clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_grant[d] = -1;
            m_left[d]  = 0;
            m_last[d]  = NR - 1;
            m_owner[d] = 0;
        end
    endfunction

    task automatic model_check();
        for (int d = 0; d < 2; d++) begin
            int          g  = m_grant[d];
            bit          wr = (g >= 0) && req[g] && !full;
            logic [63:0] ea = wr ? (64'd1 << g) : 64'd0;
            logic [63:0] ed = wr ? 64'(word[g]) : 64'd0;
            string       p  = (d == 0) ? "bl8" : "bl1";
            check_output({p, "_ack"},   64'(ack_w[d]),  ea);
            check_output({p, "_wrreq"}, 64'(wr_w[d]),   64'(wr));
            check_output({p, "_busy"},  64'(busy_w[d]), 64'(g >= 0));
            check_output({p, "_owner"}, 64'(own_w[d]),  64'(m_owner[d]));
            check_output({p, "_data"},  64'(dat_w[d]),  ed);
        end
    endtask

    function automatic void model_step();
        for (int d = 0; d < 2; d++) begin
            if (m_grant[d] < 0) begin
                for (int k = 1; k <= NR; k++) begin
                    int c = (m_last[d] + k) % NR;
                    if (req[c] && m_grant[d] < 0) begin
                        m_grant[d] = c;
                        m_last[d]  = c;
                        m_owner[d] = c;
                        m_left[d]  = blen[d];
                    end
                end
            end else if (req[m_grant[d]] && !full) begin
                m_left[d]--;
                if (m_left[d] == 0) m_grant[d] = -1;
            end else if (!req[m_grant[d]]) begin
                m_grant[d] = -1;
            end
        end
    endfunction

    // Inputs change on the falling edge; outputs are compared 2 time units later, well before the rising edge.
    task automatic apply_stimulus(input logic [NR-1:0] r, input logic f);
        @(negedge w_clk);
        req  = r;
        full = f;
        for (int i = 0; i < NR; i++) word[i] = nxt_word[i];
        #2;
        model_check();
        model_step();
    endtask

    task automatic do_reset();
        @(negedge w_clk);
        wrst = 1'b1;
        req  = '0;
        full = 1'b0;
        @(posedge w_clk);
        #1;
        wrst = 1'b0;
        model_reset();
    endtask

    task automatic add(input logic [NR-1:0] r, input logic f, input logic [NR-1:0] a,
                       input logic b, input logic [1:0] o, input int n);
        vec_t v;
        v = '{req: r, full: f, ack: a, busy: b, owner: o};
        repeat (n) tbl.push_back(v);
    endtask

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            nxt_word[i] = 32'hC0DE_0000 | 32'(i);
            word[i]     = nxt_word[i];
        end
        model_reset();

        // Reset held with everyone requesting: nothing may be granted or written.
        req = 4'b1111;
        @(negedge w_clk);
        @(negedge w_clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            check_output("rst_ack",   64'(ack_w[d]),  64'd0);
            check_output("rst_wrreq", 64'(wr_w[d]),   64'd0);
            check_output("rst_busy",  64'(busy_w[d]), 64'd0);
            check_output("rst_owner", 64'(own_w[d]),  64'd0);
            check_output("rst_data",  64'(dat_w[d]),  64'd0);
        end
        @(posedge w_clk);
        #1;
        wrst = 1'b0;
        model_reset();

        // Round-robin with all requesting: idle bubble, then 8 words each to 0,1,2,3,0.
        for (int c = 0; c < 45; c++) begin
            int act;
            int exp;
            apply_stimulus(4'b1111, 1'b0);
            case (ack_w[0])
                4'b0000: act = -1;
                4'b0001: act = 0;
                4'b0010: act = 1;
                4'b0100: act = 2;
                4'b1000: act = 3;
                default: act = 99;
            endcase
            exp = ((c % 9) == 0) ? -1 : ((c / 9) % NR);
            check_output("rr_seq", 64'(act), 64'(exp));
        end

        // Early release by owner 2, then a fifo_full stall mid-burst for owner 3, then release to idle.
        add(4'b1100, 1'b0, 4'b0000, 1'b0, 2'd0, 1);
        add(4'b1100, 1'b0, 4'b0100, 1'b1, 2'd2, 3);
        add(4'b1000, 1'b0, 4'b0000, 1'b1, 2'd2, 1);
        add(4'b1000, 1'b0, 4'b0000, 1'b0, 2'd2, 1);
        add(4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 4);
        add(4'b1000, 1'b1, 4'b0000, 1'b1, 2'd3, 5);
        add(4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 4);
        add(4'b1000, 1'b0, 4'b0000, 1'b0, 2'd3, 1);
        add(4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 1);
        add(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, 1);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 1);
        do_reset();
        foreach (tbl[n]) begin
            logic [DW-1:0] ed;
            ed = '0;
            apply_stimulus(tbl[n].req, tbl[n].full);
            for (int i = 0; i < NR; i++) if (tbl[n].ack[i]) ed = word[i];
            check_output("tbl_ack",   64'(ack_w[0]),  64'(tbl[n].ack));
            check_output("tbl_wrreq", 64'(wr_w[0]),   64'(|tbl[n].ack));
            check_output("tbl_busy",  64'(busy_w[0]), 64'(tbl[n].busy));
            check_output("tbl_owner", 64'(own_w[0]),  64'(tbl[n].owner));
            check_output("tbl_data",  64'(dat_w[0]),  64'(ed));
        end

        // Reset pulse between edges while owner 1 presents its sixth word.
        do_reset();
        repeat (15) apply_stimulus(4'b1111, 1'b0);
        apply_stimulus(4'b1111, 1'b0);
        check_output("mid_pre_ack", 64'(ack_w[0]), 64'h2);
        #1;
        wrst = 1'b1;
        #1;
        check_output("mid_ack",   64'(ack_w[0]),  64'd0);
        check_output("mid_wrreq", 64'(wr_w[0]),   64'd0);
        check_output("mid_busy",  64'(busy_w[0]), 64'd0);
        check_output("mid_owner", 64'(own_w[0]),  64'd0);
        check_output("mid_data",  64'(dat_w[0]),  64'd0);
        wrst = 1'b0;
        model_reset();
        model_step();
        apply_stimulus(4'b1111, 1'b0);
        check_output("post_rst_owner", 64'(own_w[0]), 64'd0);
        check_output("post_rst_ack",   64'(ack_w[0]), 64'h1);

        // Random tagged stream: requesters hold each word until acked, fifo_full toggles randomly.
        do_reset();
        acked = '0;
        for (int i = 0; i < NR; i++) begin
            seq[i]     = 0;
            exp_seq[i] = 0;
        end
        for (int c = 0; c < 600; c++) begin
            logic [NR-1:0] nr;
            for (int i = 0; i < NR; i++) begin
                if (acked[i]) begin
                    seq[i]++;
                    nr[i] = ($urandom_range(0, 3) != 0);
                end else if (!req[i]) begin
                    nr[i] = ($urandom_range(0, 1) != 0);
                end else begin
                    nr[i] = 1'b1;
                end
                nxt_word[i] = {8'(i), 24'(seq[i])};
            end
            apply_stimulus(nr, ($urandom_range(0, 3) == 0));
            acked = ack_w[0];
            if (wr_w[0]) sb_q.push_back(dat_w[0]);
        end
        foreach (sb_q[n]) begin
            int id;
            id = int'(sb_q[n][31:24]);
            if (id < NR) begin
                check_output("sb_order", 64'(sb_q[n][23:0]), 64'(exp_seq[id]));
                exp_seq[id]++;
            end else begin
                check_output("sb_id", 64'(id), 64'(NR - 1));
            end
        end
        for (int i = 0; i < NR; i++) begin
            check_output("sb_count", 64'(exp_seq[i]), 64'(seq[i] + (acked[i] ? 1 : 0)));
        end
        check_output("sb_volume", 64'(sb_q.size() > 100), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
